rd_reg_bank: RTL and testbench

Register bank with write-enabled storage and a handshaked read port. Writers update one of `DEPTH` 32-bit registers per cycle using the same write-enable semantics as the team's single registers. A reader issues address requests and receives data over a valid/ready response channel. The block sits between configuration/status writers and a bus-side reader, and returns register contents with one-cycle latency and full back-pressure.

---
 rtl/rd_reg_bank.sv | 99 +++++++++
 tb/tb_rd_reg_bank.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rd_reg_bank.sv
// rd_reg_bank: DEPTH x 32-bit register bank with a one-deep, back-pressured read
// response channel. Build option RD_REG_BANK_CLEAR_ON_READ_EN makes an accepted
// in-range read clear the register it returns (a same-edge write still wins).
//
// state   | meaning
// S_EMPTY | no response held, rd_valid_out=0
// S_FULL  | response held in rd_data_q/rd_err_q, rd_valid_out=1
module rd_reg_bank #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_in,
  input  logic [AW-1:0] wr_addr_in,
  input  logic [31:0]   data_in,
  input  logic          rd_req_in,
  input  logic [AW-1:0] rd_addr_in,
  output logic          rd_ack_out,
  output logic          rd_valid_out,
  output logic [31:0]   rd_data_out,
  output logic          rd_err_out,
  input  logic          rd_ready_in
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t      state_q, state_d;
  logic [31:0] r_q [DEPTH];
  logic [31:0] r_d [DEPTH];
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_err_q, rd_err_d;
  logic        accept;
  logic        rd_in_range;
  logic [31:0] rd_word;

  // Read address decode; the mux sees pre-edge contents so same-edge writes are invisible
  always_comb begin
    rd_in_range = ({1'b0, rd_addr_in} < DEPTH_W);
    rd_word     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr_in == AW'(i)) rd_word = r_q[i];
    end
  end

  // FSM outputs: valid from state, ack combinational from state and consumer ready
  always_comb begin
    rd_valid_out = (state_q == S_FULL);
    rd_ack_out   = rst && rd_req_in && ((state_q == S_EMPTY) || rd_ready_in);
    accept       = rd_ack_out;
  end

  assign rd_data_out = rd_data_q;
  assign rd_err_out  = rd_err_q;

  // FSM next state and response register reload on accept
  always_comb begin
    state_d   = state_q;
    rd_data_d = rd_data_q;
    rd_err_d  = rd_err_q;
    if (accept) begin
      state_d   = S_FULL;
      rd_data_d = rd_in_range ? rd_word : 32'd0;
      rd_err_d  = !rd_in_range;
    end else if ((state_q == S_FULL) && rd_ready_in) begin
      state_d = S_EMPTY;
    end
  end

  // Storage next value: optional clear-on-read first, so a same-address write overrides it
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      r_d[i] = r_q[i];
`ifdef RD_REG_BANK_CLEAR_ON_READ_EN
      if (accept && (rd_addr_in == AW'(i))) r_d[i] = 32'd0;
`else
`endif
      if (wr_in && (wr_addr_in == AW'(i))) r_d[i] = data_in;
    end
  end

  // All state, with synchronous active-low reset overriding everything
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_EMPTY;
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      rd_data_q <= rd_data_d;
      rd_err_q  <= rd_err_d;
      for (int i = 0; i < DEPTH; i++) r_q[i] <= r_d[i];
    end
  end

endmodule

// File: tb/tb_rd_reg_bank.sv
// Bench for rd_reg_bank: a DEPTH=4 and a DEPTH=3 instance share one stimulus
// stream and are each checked every cycle against a behavioural model.
module tb_rd_reg_bank;

  logic        clk;
  logic        rst;
  logic        wr_in;
  logic [1:0]  wr_addr_in;
  logic [31:0] data_in;
  logic        rd_req_in;
  logic [1:0]  rd_addr_in;
  logic        rd_ready_in;

  logic [1:0]  ack_o;
  logic [1:0]  valid_o;
  logic [1:0]  err_o;
  logic [31:0] data_o [2];

  int errors = 0;
  int checks = 0;

  // behavioural model state per instance
  int          dep [2] = '{4, 3};
  logic [31:0] mmem [2][4];
  logic        mvalid [2];
  logic [31:0] mdata [2];
  logic        merr [2];

  rd_reg_bank #(.DEPTH(4), .AW(2)) u_dut4 (
    .clk(clk), .rst(rst), .wr_in(wr_in), .wr_addr_in(wr_addr_in), .data_in(data_in),
    .rd_req_in(rd_req_in), .rd_addr_in(rd_addr_in), .rd_ack_out(ack_o[0]),
    .rd_valid_out(valid_o[0]), .rd_data_out(data_o[0]), .rd_err_out(err_o[0]),
    .rd_ready_in(rd_ready_in)
  );

  rd_reg_bank #(.DEPTH(3), .AW(2)) u_dut3 (
    .clk(clk), .rst(rst), .wr_in(wr_in), .wr_addr_in(wr_addr_in), .data_in(data_in),
    .rd_req_in(rd_req_in), .rd_addr_in(rd_addr_in), .rd_ack_out(ack_o[1]),
    .rd_valid_out(valid_o[1]), .rd_data_out(data_o[1]), .rd_err_out(err_o[1]),
    .rd_ready_in(rd_ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, k, act, exp, $time);
    end
  endtask

  // advance the model by one rising edge using the current inputs
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        for (int a = 0; a < 4; a++) mmem[k][a] = '0;
        mvalid[k] = 1'b0;
        mdata[k]  = '0;
        merr[k]   = 1'b0;
      end else begin
        logic acc;
        logic inr;
        acc = rd_req_in && (!mvalid[k] || rd_ready_in);
        inr = int'(rd_addr_in) < dep[k];
        if (acc) begin
          mvalid[k] = 1'b1;
          mdata[k]  = inr ? mmem[k][rd_addr_in] : 32'd0;
          merr[k]   = !inr;
`ifdef RD_REG_BANK_CLEAR_ON_READ_EN
          if (inr) mmem[k][rd_addr_in] = 32'd0;
`endif
        end else if (rd_ready_in) begin
          mvalid[k] = 1'b0;
        end
        if (wr_in && int'(wr_addr_in) < dep[k]) mmem[k][wr_addr_in] = data_in;
      end
    end
  endtask

  // one cycle: compare on the falling edge, then take the rising edge
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("ack", k, 32'(ack_o[k]), 32'(rst && rd_req_in && (!mvalid[k] || rd_ready_in)));
      chk("valid", k, 32'(valid_o[k]), 32'(mvalid[k]));
      if (mvalid[k]) begin
        chk("data", k, data_o[k], mdata[k]);
        chk("err", k, 32'(err_o[k]), 32'(merr[k]));
      end
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [1:0] wa, input logic [31:0] wd,
                       input logic rq, input logic [1:0] ra, input logic rdy);
    rst = r; wr_in = w; wr_addr_in = wa; data_in = wd;
    rd_req_in = rq; rd_addr_in = ra; rd_ready_in = rdy;
  endtask

  task automatic lit(input string name, input int k, input logic v, input logic [31:0] d, input logic e);
    chk({name, "_valid"}, k, 32'(valid_o[k]), 32'(v));
    chk({name, "_data"}, k, data_o[k], d);
    chk({name, "_err"}, k, 32'(err_o[k]), 32'(e));
  endtask

  initial begin
    drive(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 2'd0, 1'b1);
    @(posedge clk);
    model_edge();
    #1;
    step();
    chk("rst_ack", 0, 32'(ack_o[0]), 32'd0);
    for (int k = 0; k < 2; k++) lit("reset", k, 1'b0, 32'd0, 1'b0);

    // reset then read
    drive(1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 2'd0, 1'b1);
    step();
    for (int k = 0; k < 2; k++) lit("first_read", k, 1'b1, 32'd0, 1'b0);

    // write then read next edge; then same-edge write and read
    drive(1'b1, 1'b1, 2'd2, 32'hDEADBEEF, 1'b0, 2'd0, 1'b1);
    step();
    drive(1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 2'd2, 1'b1);
    step();
    for (int k = 0; k < 2; k++) lit("wr_then_rd", k, 1'b1, 32'hDEADBEEF, 1'b0);
    drive(1'b1, 1'b1, 2'd1, 32'h12345678, 1'b1, 2'd1, 1'b1);
    step();
    for (int k = 0; k < 2; k++) lit("same_edge", k, 1'b1, 32'd0, 1'b0);

    // back-pressure
    drive(1'b1, 1'b1, 2'd1, 32'h11, 1'b0, 2'd0, 1'b1);
    step();
    drive(1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 2'd1, 1'b0);
    step();
    lit("bp_load", 0, 1'b1, 32'h11, 1'b0);
    drive(1'b1, 1'b1, 2'd1, 32'h22, 1'b1, 2'd0, 1'b0);
    #1;
    chk("bp_ack", 0, 32'(ack_o[0]), 32'd0);
    step();
    lit("bp_hold1", 0, 1'b1, 32'h11, 1'b0);
    drive(1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 1'b0);
    step();
    lit("bp_hold2", 0, 1'b1, 32'h11, 1'b0);
    drive(1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 1'b1);
    step();
    chk("bp_done", 0, 32'(valid_o[0]), 32'd0);

    // streaming, including out-of-range for the DEPTH=3 instance
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 2'(i), 32'hA0 + 32'(i), 1'b0, 2'd0, 1'b1);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 2'(i), 1'b1);
      step();
      lit("stream", 0, 1'b1, 32'hA0 + 32'(i), 1'b0);
      if (i < 3) lit("stream3", 1, 1'b1, 32'hA0 + 32'(i), 1'b0);
      else       lit("oor", 1, 1'b1, 32'd0, 1'b1);
    end
    drive(1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 1'b1);
    step();

    // read side effects (clear-on-read when built with it)
    drive(1'b1, 1'b1, 2'd0, 32'h55, 1'b0, 2'd0, 1'b1);
    step();
    drive(1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 2'd0, 1'b1);
    step();
    lit("cor_first", 0, 1'b1, 32'h55, 1'b0);
    step();
`ifdef RD_REG_BANK_CLEAR_ON_READ_EN
    lit("cor_second", 0, 1'b1, 32'h0, 1'b0);
`else
    lit("cor_second", 0, 1'b1, 32'h55, 1'b0);
`endif
    drive(1'b1, 1'b1, 2'd0, 32'h55, 1'b0, 2'd0, 1'b1);
    step();
    drive(1'b1, 1'b1, 2'd0, 32'h77, 1'b1, 2'd0, 1'b1);
    step();
    lit("cor_wr_first", 0, 1'b1, 32'h55, 1'b0);
    drive(1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 2'd0, 1'b1);
    step();
    lit("cor_wr_second", 0, 1'b1, 32'h77, 1'b0);

    // mid-operation reset while FULL with ready low
    drive(1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 2'd2, 1'b0);
    step();
    drive(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 1'b0);
    step();
    for (int k = 0; k < 2; k++) lit("mid_rst", k, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 2'(i), 1'b1);
      step();
      lit("post_rst", 0, 1'b1, 32'd0, 1'b0);
    end

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(63) != 0), 1'($urandom), 2'($urandom), $urandom,
            ($urandom_range(3) != 0), 2'($urandom), ($urandom_range(2) != 0));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
